// File: rtl/r4b.sv
// r4b: clock-enabled storage register with 2:1 input mux and synchronous clear.
// Latency: one cycle, from the sampling edge of C to Q; Q is driven only by flops.
// Backpressure: none; CE is a load enable, and Q holds while CE is low.
// Optional build macro R4B_CHANGE_FLAG_EN adds the registered change flag Chg.
module r4b #(
  parameter int WIDTH = 4
) (
  input  logic             S,
  input  logic             C,
  input  logic             CE,
  input  logic             Clr,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  output logic [WIDTH-1:0] Q
`ifdef R4B_CHANGE_FLAG_EN
  ,
  output logic             Chg
`endif
);

  // Word that a load would capture. It is combinational and sits ahead of the flops.
  logic [WIDTH-1:0] d_sel;

  // Input select. An unknown S is not masked, so it reaches Q on a load.
  always_comb begin
    d_sel = S ? I1 : I0;
  end

  // Storage register. Clear has priority over load, and load has priority over hold.
  always_ff @(posedge C) begin
    if (Clr) begin
      Q <= '0;
    end else if (CE) begin
      Q <= d_sel;
    end
  end

`ifdef R4B_CHANGE_FLAG_EN
  // Change flag. It is set only when a load writes a value different from the current Q.
  // A hold edge never changes Q, so the flag falls to 0 on that edge.
  always_ff @(posedge C) begin
    if (Clr) begin
      Chg <= 1'b0;
    end else begin
      Chg <= CE && (d_sel != Q);
    end
  end
`endif

endmodule

// File: tb/tb_r4b.sv
// Self-checking bench for r4b: directed cases, then random cycles checked against a reference model.
// It builds with or without R4B_CHANGE_FLAG_EN and checks Chg when the flag is present.
module tb_r4b;

  localparam int W = 4;

  logic         S;
  logic         C;
  logic         CE;
  logic         Clr;
  logic [W-1:0] I0;
  logic [W-1:0] I1;
  logic [W-1:0] Q;
`ifdef R4B_CHANGE_FLAG_EN
  logic         Chg;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state, updated from the operating rules at each edge.
  logic [W-1:0] m_q;
  logic         m_chg;

  r4b #(.WIDTH(W)) dut (
    .S   (S),
    .C   (C),
    .CE  (CE),
    .Clr (Clr),
    .I0  (I0),
    .I1  (I1),
    .Q   (Q)
`ifdef R4B_CHANGE_FLAG_EN
    ,
    .Chg (Chg)
`endif
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after the falling edge and check that Q has not moved.
  // Then advance one rising edge and check Q (and Chg) against the model.
  task automatic step(input string tag, input logic clr, input logic ce, input logic s,
                      input logic [W-1:0] i0, input logic [W-1:0] i1);
    logic [W-1:0] nxt;
    @(negedge C);
    Clr = clr; CE = ce; S = s; I0 = i0; I1 = i1;
    #1;
    check({tag, "_nocomb"}, Q, m_q);
    @(posedge C);
    #1;
    if (clr)      nxt = '0;
    else if (ce)  nxt = s ? i1 : i0;
    else          nxt = m_q;
    m_chg = clr ? 1'b0 : (nxt != m_q);
    m_q   = nxt;
    check(tag, Q, m_q);
`ifdef R4B_CHANGE_FLAG_EN
    check({tag, "_chg"}, Chg, m_chg);
`endif
  endtask

  initial begin
    Clr = 1'b0; CE = 1'b0; S = 1'b0; I0 = '0; I1 = '0;
    m_q = 'x; m_chg = 1'b0;

    // Clear while CE is also high. This is the first defined state of Q.
    @(negedge C);
    Clr = 1'b1; CE = 1'b1; S = 1'b0; I0 = 4'b1010; I1 = 4'b0000;
    @(posedge C);
    #1;
    m_q = '0; m_chg = 1'b0;
    check("reset_q", Q, 4'b0000);
`ifdef R4B_CHANGE_FLAG_EN
    check("reset_chg", Chg, 1'b0);
`endif

    // Directed cases from the operating rules.
    step("load_i0",   1'b0, 1'b1, 1'b0, 4'b1010, 4'b1011);
    check("load_i0_val", Q, 4'b1010);
    for (int k = 0; k < 5; k++)
      step("hold",    1'b0, 1'b0, k[0], 4'b1111, 4'b1110);
    check("hold_val", Q, 4'b1010);
    step("load_i1",   1'b0, 1'b1, 1'b1, 4'b1111, 4'b0110);
    check("load_i1_val", Q, 4'b0110);
    step("load_i0b",  1'b0, 1'b1, 1'b0, 4'b0001, 4'b0110);
    check("load_i0b_val", Q, 4'b0001);
    step("reload",    1'b0, 1'b1, 1'b1, 4'b0001, 4'b0110);
    step("clr_prio",  1'b1, 1'b1, 1'b1, 4'b0001, 4'b1111);
    check("clr_prio_val", Q, 4'b0000);
    step("clr_multi", 1'b1, 1'b0, 1'b0, 4'b1111, 4'b1111);
    step("after_clr", 1'b0, 1'b1, 1'b1, 4'b0001, 4'b1111);
    check("after_clr_val", Q, 4'b1111);
    step("clr_again", 1'b1, 1'b1, 1'b0, 4'b0101, 4'b0000);
    step("chg_set",   1'b0, 1'b1, 1'b0, 4'b0101, 4'b0000);
    step("chg_same",  1'b0, 1'b1, 1'b1, 4'b0000, 4'b0101);
    step("chg_clr",   1'b1, 1'b1, 1'b0, 4'b1111, 4'b1111);

    // Random cycles. Clear is rare and CE is high most of the time.
    for (int n = 0; n < 400; n++) begin
      step("rand",
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) < 6),
           1'($urandom),
           W'($urandom),
           W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
